// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - op codes, FSM encoding and result helpers shared by calc_seq
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divide-by-zero result: the low `width` bits set, everything above clear.
  function automatic logic [63:0] div0_result(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// rtl/calc_iter_unit.sv - shift-add multiplier and restoring divider, one step per cycle
module calc_iter_unit #(
  parameter int WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product,
  output logic [WIDTH-1:0]   o_quotient,
  output logic [WIDTH-1:0]   o_remainder,
  output logic               o_last
);
  import calc_pkg::*;

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // r_acc: product accumulator (mul) or partial remainder (div).
  // r_dsr: shifting multiplicand (mul) or divisor (div).
  // r_opnd: multiplier shifted right (mul) or dividend/quotient shifted left (div).
  logic              r_active;
  logic              r_mode;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_acc;
  logic [RW-1:0]     r_dsr;
  logic [WIDTH-1:0]  r_opnd;

  logic [RW-1:0]     w_mul_acc;
  logic [WIDTH:0]    w_shifted;
  logic              w_ge;
  logic [WIDTH-1:0]  w_rem_next;
  logic [WIDTH-1:0]  w_quo_next;

  // Outputs are the post-step values so the top can capture the final step on the same edge.
  always_comb begin
    w_mul_acc  = r_opnd[0] ? (r_acc + r_dsr) : r_acc;
    w_shifted  = {r_acc[WIDTH-1:0], r_opnd[WIDTH-1]};
    w_ge       = (w_shifted >= {1'b0, r_dsr[WIDTH-1:0]});
    w_rem_next = w_ge ? WIDTH'(w_shifted - {1'b0, r_dsr[WIDTH-1:0]}) : w_shifted[WIDTH-1:0];
    w_quo_next = {r_opnd[WIDTH-2:0], w_ge};
  end

  assign o_product   = w_mul_acc;
  assign o_quotient  = w_quo_next;
  assign o_remainder = w_rem_next;
  assign o_last      = r_active && (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_mode   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_dsr    <= '0;
      r_opnd   <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_mode   <= i_mode;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_dsr    <= i_mode ? RW'(i_b) : RW'(i_a);
      r_opnd   <= i_mode ? i_a : i_b;
    end else if (r_active) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_mode) begin
        r_acc  <= RW'(w_rem_next);
        r_opnd <= w_quo_next;
      end else begin
        r_acc  <= w_mul_acc;
        r_dsr  <= r_dsr << 1;
        r_opnd <= r_opnd >> 1;
      end
      if (r_cnt == LAST_CNT) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - key-driven sequential add/sub/mul/div calculator core
module calc_seq #(
  parameter int WIDTH = 4
) (
  input  logic               CLK_28,
  input  logic               rst,
  input  logic [3:0]         KEY_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic [1:0]         op,
  output logic               busy,
  output logic               done,
  output logic               neg,
  output logic               div0
);
  import calc_pkg::*;

  localparam int RW = 2 * WIDTH;

  state_t            r_state;
  logic [3:0]        r_key_q;

  logic [3:0]        w_press;
  logic              w_any;
  logic [1:0]        w_sel;
  logic              w_start;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH-1:0]  w_diff;
  logic [RW-1:0]     w_product;
  logic [WIDTH-1:0]  w_quotient;
  logic [WIDTH-1:0]  w_rem;
  logic              w_last;

  always_comb begin
    w_press = r_key_q & ~KEY_n;
    w_any   = |w_press;
    if (w_press[0])      w_sel = OP_ADD;
    else if (w_press[1]) w_sel = OP_SUB;
    else if (w_press[2]) w_sel = OP_MUL;
    else                 w_sel = OP_DIV;
    w_start = (r_state == ST_IDLE) && w_any &&
              ((w_sel == OP_MUL) || ((w_sel == OP_DIV) && (b != '0)));
    w_sum   = {1'b0, a} + {1'b0, b};
    w_diff  = a - b;
  end

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .i_clk       (CLK_28),
    .i_rst       (rst),
    .i_start     (w_start),
    .i_mode      (w_sel == OP_DIV),
    .i_a         (a),
    .i_b         (b),
    .o_product   (w_product),
    .o_quotient  (w_quotient),
    .o_remainder (w_rem),
    .o_last      (w_last)
  );

  always_ff @(posedge CLK_28) begin
    if (rst) begin
      r_key_q   <= 4'hF;
      r_state   <= ST_IDLE;
      result    <= '0;
      remainder <= '0;
      op        <= OP_ADD;
      busy      <= 1'b0;
      done      <= 1'b0;
      neg       <= 1'b0;
      div0      <= 1'b0;
    end else begin
      r_key_q <= KEY_n;
      done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            op   <= w_sel;
            busy <= 1'b1;
            case (w_sel)
              OP_ADD: begin
                result    <= RW'(w_sum);
                remainder <= '0;
                neg       <= 1'b0;
                div0      <= 1'b0;
                done      <= 1'b1;
                r_state   <= ST_DONE;
              end
              OP_SUB: begin
                result    <= RW'(w_diff);
                remainder <= '0;
                neg       <= (a < b);
                div0      <= 1'b0;
                done      <= 1'b1;
                r_state   <= ST_DONE;
              end
              OP_MUL: r_state <= ST_CALC;
              default: begin
                if (b == '0) begin
                  result    <= RW'(div0_result(WIDTH));
                  remainder <= a;
                  neg       <= 1'b0;
                  div0      <= 1'b1;
                  done      <= 1'b1;
                  r_state   <= ST_DONE;
                end else begin
                  r_state <= ST_CALC;
                end
              end
            endcase
          end
        end
        ST_CALC: begin
          if (w_last) begin
            if (op == OP_MUL) begin
              result    <= w_product;
              remainder <= '0;
            end else begin
              result    <= RW'(w_quotient);
              remainder <= w_rem;
            end
            neg     <= 1'b0;
            div0    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq.sv
// tb/tb_calc_seq.sv - randomized and directed checks of calc_seq at WIDTH 4 and 8
module tb_calc_seq;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic [31:0] op;
    logic        busy;
    logic        done;
    logic        neg;
    logic        div0;
  } obs_t;

  int n_checks = 0;
  int n_errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] k4, k8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;

  wire [7:0]  res4;
  wire [3:0]  rem4;
  wire [1:0]  op4;
  wire        busy4, done4, neg4, div04;
  wire [15:0] res8;
  wire [7:0]  rem8;
  wire [1:0]  op8;
  wire        busy8, done8, neg8, div08;

  calc_seq #(.WIDTH(4)) dut4 (
    .CLK_28(clk), .rst(rst), .KEY_n(k4), .a(a4), .b(b4),
    .result(res4), .remainder(rem4), .op(op4), .busy(busy4),
    .done(done4), .neg(neg4), .div0(div04)
  );

  calc_seq #(.WIDTH(8)) dut8 (
    .CLK_28(clk), .rst(rst), .KEY_n(k8), .a(a8), .b(b8),
    .result(res8), .remainder(rem8), .op(op8), .busy(busy8),
    .done(done8), .neg(neg8), .div0(div08)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample(input int d, output obs_t o);
    if (d == 0) begin
      o.res = 32'(res4); o.rem = 32'(rem4); o.op = 32'(op4);
      o.busy = busy4; o.done = done4; o.neg = neg4; o.div0 = div04;
    end else begin
      o.res = 32'(res8); o.rem = 32'(rem8); o.op = 32'(op8);
      o.busy = busy8; o.done = done8; o.neg = neg8; o.div0 = div08;
    end
  endtask

  task automatic drive(input int d, input logic [3:0] keys, input logic [7:0] av, input logic [7:0] bv);
    if (d == 0) begin
      k4 = keys; a4 = av[3:0]; b4 = bv[3:0];
    end else begin
      k8 = keys; a8 = av; b8 = bv;
    end
  endtask

  // Reference: plain arithmetic on the operands, with the documented latency per operation.
  task automatic model(input int w, input logic [3:0] keys, input int av, input int bv,
                       output int opc, output int lat, output logic [31:0] er,
                       output logic [31:0] erem, output logic en, output logic ed0);
    int mask;
    mask = (1 << w) - 1;
    opc  = keys[0] ? 0 : keys[1] ? 1 : keys[2] ? 2 : 3;
    er = 0; erem = 0; en = 1'b0; ed0 = 1'b0; lat = w + 1;
    case (opc)
      0: begin er = 32'(av + bv); lat = 1; end
      1: begin er = 32'((av - bv) & mask); en = (av < bv); lat = 1; end
      2: er = 32'(av * bv);
      default: begin
        if (bv == 0) begin
          er = 32'(mask); erem = 32'(av); ed0 = 1'b1; lat = 1;
        end else begin
          er = 32'(av / bv); erem = 32'(av % bv);
        end
      end
    endcase
  endtask

  task automatic check_all_zero(input int d, input string tag);
    obs_t o;
    sample(d, o);
    check({tag, " result"}, o.res, 0);
    check({tag, " remainder"}, o.rem, 0);
    check({tag, " op"}, o.op, 0);
    check({tag, " busy"}, 32'(o.busy), 0);
    check({tag, " done"}, 32'(o.done), 0);
    check({tag, " neg"}, 32'(o.neg), 0);
    check({tag, " div0"}, 32'(o.div0), 0);
  endtask

  // Press keys for one sampling edge, then follow the operation cycle by cycle.
  task automatic run_op(input int d, input logic [3:0] keys, input int av, input int bv, input bit inject);
    int w, opc, lat;
    logic [31:0] er, erem;
    logic en, ed0;
    obs_t o;
    string t;
    w = (d == 0) ? 4 : 8;
    model(w, keys, av, bv, opc, lat, er, erem, en, ed0);
    drive(d, ~keys, 8'(av), 8'(bv));
    @(posedge clk); #1;
    drive(d, 4'hF, 8'($urandom), 8'($urandom));
    for (int j = 1; j <= lat + 2; j++) begin
      sample(d, o);
      t = $sformatf("w%0d op%0d a%0d b%0d c%0d", w, opc, av, bv, j);
      check({t, " busy"}, 32'(o.busy), 32'(j <= lat));
      check({t, " done"}, 32'(o.done), 32'(j == lat));
      if (j >= lat) begin
        check({t, " result"}, o.res, er);
        check({t, " remainder"}, o.rem, erem);
        check({t, " op"}, o.op, 32'(opc));
        check({t, " neg"}, 32'(o.neg), 32'(en));
        check({t, " div0"}, 32'(o.div0), 32'(ed0));
      end
      if (inject && lat > 4 && j == 2) drive(d, 4'b1110, 8'($urandom), 8'($urandom));
      if (inject && lat > 4 && j == 3) drive(d, 4'hF, 8'($urandom), 8'($urandom));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t o;
    int d, w, av, bv;
    logic [3:0] keys;
    bit inj;

    rst = 1'b1;
    drive(0, 4'hF, 8'd0, 8'd0);
    drive(1, 4'hF, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero(0, "reset w4");
    check_all_zero(1, "reset w8");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero(0, "post-reset w4");
    check_all_zero(1, "post-reset w8");

    run_op(0, 4'b0001, 9, 8, 1'b0);
    run_op(0, 4'b0010, 3, 5, 1'b0);
    run_op(0, 4'b0010, 5, 3, 1'b0);
    run_op(0, 4'b0100, 15, 15, 1'b0);
    run_op(1, 4'b1000, 200, 7, 1'b1);
    run_op(1, 4'b1000, 200, 0, 1'b0);
    run_op(0, 4'b0101, 9, 8, 1'b0);

    drive(0, 4'b1011, 8'd15, 8'd15);
    @(posedge clk); #1;
    drive(0, 4'hF, 8'd15, 8'd15);
    @(posedge clk); #1;
    sample(0, o);
    check("mul before abort busy", 32'(o.busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check_all_zero(0, $sformatf("abort c%0d", j));
      @(posedge clk); #1;
    end

    for (int i = 0; i < 60; i++) begin
      d = int'($urandom_range(0, 1));
      w = (d == 0) ? 4 : 8;
      keys = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) keys = keys | 4'($urandom);
      av = int'($urandom_range(0, (1 << w) - 1));
      bv = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, (1 << w) - 1));
      inj = ($urandom_range(0, 2) == 0);
      run_op(d, keys, av, bv, inj);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
